instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage directly upstream of the single-cycle RV32I core. Takes the
//  core's PC, issues word reads to instruction memory over a req/gnt/rvalid bus,
//  prefetches sequential words (PC+4) into a small FIFO and presents {instr, pc} to the
//  core with a valid/ready handshake. Any PC not matching the expected stream flushes.
// PARAMETERS
//  DEPTH     2            prefetch FIFO entries (power of 2, >=2)
//  RESET_PC  32'h0000_0000  first fetch address after reset
// PORTS
//  clk            in   1   clock, all state on posedge
//  resetn         in   1   asynchronous, active-low reset
//  fetch_pc_i     in   32  PC the core wants to execute this cycle
//  instr_o        out  32  instruction word at FIFO head
//  instr_pc_o     out  32  address of instr_o
//  instr_valid_o  out  1   instr_o valid and instr_pc_o == fetch_pc_i
//  instr_ready_i  in   1   core consumes head entry this cycle
//  instr_illegal_o out 1   head entry failed opcode check (see CONFIGURATION)
//  mem_req_o      out  1   memory read request
//  mem_addr_o     out  32  word address, bits[1:0] always 0
//  mem_gnt_i      in   1   request accepted this cycle
//  mem_rvalid_i   in   1   read data valid (>=1 cycle after gnt)
//  mem_rdata_i    in   32  read data
// BEHAVIOUR
//  - Reset: instr_valid_o=0, instr_illegal_o=0, mem_req_o=0, mem_addr_o=0, FIFO empty,
//    nxt_addr=RESET_PC, discard=0, state IDLE. Reset mid-transaction abandons it.
//  - FSM: IDLE -> REQ when (count + in-flight) < DEPTH; REQ holds mem_req_o=1 and
//    mem_addr_o stable until mem_gnt_i (no withdrawal); on gnt -> WAIT,
//    pend_pc<=nxt_addr, nxt_addr+=4; WAIT -> IDLE on mem_rvalid_i. One outstanding max.
//  - On rvalid with discard=0: push {mem_rdata_i, pend_pc}; with discard=1: drop, clear.
//  - expected_pc = head pc if FIFO non-empty, else pend_pc if WAIT/REQ-granted, else nxt_addr.
//  - Redirect when fetch_pc_i != expected_pc: same cycle instr_valid_o=0; next edge
//    FIFO flushed, nxt_addr<=fetch_pc_i; if a request is outstanding or in REQ, it
//    completes on the bus and its data is discarded (discard<=1).
//  - Pop on instr_valid_o && instr_ready_i; push and pop same cycle legal when full.
//  - Full FIFO: no new request issued; rvalid never arrives to a full FIFO by the
//    count+in-flight rule.
//  - nxt_addr wraps 32'hFFFF_FFFC -> 0 silently.
//  - Latency: redirect at cycle 0 with zero-wait memory (gnt same cycle, rvalid next):
//    req at cycle 1, push at cycle 2 edge, instr_valid_o at cycle 3. Back-to-back
//    sequential steady state: one instruction per 2 cycles at DEPTH>=2.
//  - fetch_pc_i[1:0]!=0: treated as redirect to {fetch_pc_i[31:2],2'b00}.
// CONFIGURATION
//  IFETCH_OPCODE_CHECK_EN defined: on push, opcode[6:0] not in {R, I, LOAD, JAL, JALR,
//    B, LUI, AUIPC, SYSTEM} is replaced by 32'h0000_0073 (core halt) and entry's
//    illegal bit set; instr_illegal_o reflects head entry.
//  Undefined: words pass unmodified; instr_illegal_o tied 0.
// STRUCTURE
//  ifetch_pkg: opcode localparams (shared with core), SYS_HALT_INSTR constant,
//    state enum {IDLE, REQ, WAIT}, fifo entry struct {instr, pc, illegal}.
//  Sub-module ifetch_fifo: DEPTH-entry synchronous FIFO with flush, push, pop, count.
// TESTING
//  1 Reset, zero-wait mem returning addr as data, fetch_pc_i=0, ready=1 -> first
//    instr_valid_o at cycle 3 with instr_o=0, then pc 4,8,12 in order.
//  2 Hold ready=0 -> exactly DEPTH pushes, mem_req_o stays 0 until a pop.
//  3 While WAIT for pc 8, fetch_pc_i=0x100 -> rvalid data dropped, next req addr 0x100,
//    instr_valid_o only with instr_pc_o=0x100.
//  4 mem_gnt_i low 5 cycles -> mem_req_o and mem_addr_o stable throughout.
//  5 resetn low during WAIT -> outputs to reset values immediately; refetch from RESET_PC.
//  6 OPCODE_CHECK_EN, mem returns 32'hFFFF_FFFF -> instr_o=32'h73, instr_illegal_o=1.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared definitions for the instruction fetch stage.
//  - RV32I major opcodes (shared with the core)
//  - SYS_HALT_INSTR: word substituted for rejected opcodes when
//    IFETCH_OPCODE_CHECK_EN is defined
//  - fetch FSM state enum and prefetch FIFO entry struct
//  - opcode_legal(): opcodes accepted by the optional opcode check
package ifetch_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

    localparam logic [31:0] SYS_HALT_INSTR = 32'h0000_0073;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } ifetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        illegal;
    } fifo_entry_t;

    function automatic logic opcode_legal(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_SYSTEM: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the core-side fetch handshake and the instruction
// memory req/gnt/rvalid bus of instr_fetch.
//  master: the fetch stage (drives instr_* outputs and mem_req/mem_addr)
//  slave : the environment (core + instruction memory)
interface instr_fetch_if;
    // core side
    logic [31:0] fetch_pc_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        instr_illegal_o;
    // instruction memory side
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        input  fetch_pc_i, instr_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output instr_o, instr_pc_o, instr_valid_o, instr_illegal_o, mem_req_o, mem_addr_o
    );

    modport slave (
        output fetch_pc_i, instr_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  instr_o, instr_pc_o, instr_valid_o, instr_illegal_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry synchronous prefetch FIFO of fifo_entry_t.
//  clk, resetn : clock, async active-low reset
//  flush       : empty the FIFO at the next edge (wins over push/pop)
//  push/push_data, pop : write tail / retire head (both legal when full)
//  head, empty, count  : head entry, empty flag, occupancy
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  fifo_entry_t      push_data,
    input  logic             pop,
    output fifo_entry_t      head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    fifo_entry_t      storage_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (push && !flush) storage_q[wr_ptr_q] <= push_data;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = storage_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage ahead of the RV32I core. Reads sequential words from
// instruction memory into a prefetch FIFO and presents {instr, pc} to the core.
// A fetch_pc_i that does not match the expected stream flushes and refetches.
//  clk, resetn : clock, async active-low reset
//  bus         : instr_fetch_if.master (core handshake + memory req/gnt/rvalid)
// Build option: IFETCH_OPCODE_CHECK_EN replaces words with unsupported opcodes
// by SYS_HALT_INSTR and flags them on instr_illegal_o.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          resetn,
    instr_fetch_if.master bus
);
    localparam int unsigned    CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C    = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]    RESET_ADDR = {RESET_PC[31:2], 2'b00};

    ifetch_state_e    state_q, state_d;
    logic [31:0]      nxt_addr_q, nxt_addr_d;   // next sequential fetch address
    logic [31:0]      pend_pc_q, pend_pc_d;     // address of the live outstanding read
    logic [31:0]      mem_addr_q, mem_addr_d;   // held on the bus while in StReq
    logic             discard_q, discard_d;     // outstanding read belongs to a dead stream
    fifo_entry_t      head, push_entry;
    logic             empty, push, pop, redirect, room, start_req, instr_valid;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   count_nxt;
    logic [31:0]      expected_pc, fetch_addr;

    always_comb begin
        if (!empty)                                expected_pc = head.pc;
        else if (state_q == StWait && !discard_q) expected_pc = pend_pc_q;
        else                                       expected_pc = nxt_addr_q;
    end

    // A misaligned fetch_pc_i never matches, so it redirects to its aligned word.
    assign fetch_addr  = {bus.fetch_pc_i[31:2], 2'b00};
    assign redirect    = (bus.fetch_pc_i != expected_pc);
    assign instr_valid = !empty && !redirect;
    assign pop         = instr_valid && bus.instr_ready_i;
    assign push        = (state_q == StWait) && bus.mem_rvalid_i && !discard_q && !redirect;

    // Occupancy after this edge; a new request only goes out if its data has a slot.
    assign count_nxt = redirect ? '0 : ({1'b0, count} + (CNT_W + 1)'(push) - (CNT_W + 1)'(pop));
    assign room      = (count_nxt < DEPTH_C);

    always_comb begin
        push_entry.pc = pend_pc_q;
`ifdef IFETCH_OPCODE_CHECK_EN
        if (opcode_legal(bus.mem_rdata_i[6:0])) begin
            push_entry.instr   = bus.mem_rdata_i;
            push_entry.illegal = 1'b0;
        end else begin
            push_entry.instr   = SYS_HALT_INSTR;
            push_entry.illegal = 1'b1;
        end
`else
        push_entry.instr   = bus.mem_rdata_i;
        push_entry.illegal = 1'b0;
`endif
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        state_d    = state_q;
        nxt_addr_d = nxt_addr_q;
        pend_pc_d  = pend_pc_q;
        mem_addr_d = mem_addr_q;
        discard_d  = discard_q;
        start_req  = 1'b0;

        unique case (state_q)
            StIdle: start_req = room;
            StReq: begin
                if (bus.mem_gnt_i) begin
                    state_d = StWait;
                    // A request orphaned by a redirect must not advance the stream.
                    if (!discard_q && !redirect) begin
                        pend_pc_d  = mem_addr_q;
                        nxt_addr_d = mem_addr_q + 32'd4;
                    end
                end
            end
            StWait: begin
                if (bus.mem_rvalid_i) begin
                    discard_d = 1'b0;
                    // Chain straight into the next request to sustain 1 instr / 2 cycles.
                    if (room) start_req = 1'b1;
                    else      state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redirect) begin
            nxt_addr_d = fetch_addr;
            if (state_q == StReq || (state_q == StWait && !bus.mem_rvalid_i)) discard_d = 1'b1;
        end

        if (start_req) begin
            state_d    = StReq;
            mem_addr_d = nxt_addr_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            nxt_addr_q <= RESET_ADDR;
            pend_pc_q  <= '0;
            mem_addr_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            nxt_addr_q <= nxt_addr_d;
            pend_pc_q  <= pend_pc_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
        end
    end

    assign bus.mem_req_o       = (state_q == StReq);
    assign bus.mem_addr_o      = mem_addr_q;
    assign bus.instr_valid_o   = instr_valid;
    assign bus.instr_o         = head.instr;
    assign bus.instr_pc_o      = head.pc;
    assign bus.instr_illegal_o = !empty && head.illegal;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import ifetch_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_tot = 0;
    int n_bad = 0;

    // stimulus knobs
    int gnt_pct, ready_pct, jump_pct, spont_pct, rv_min, rv_max, data_mode;
    bit live_chk;

    // environment / reference state
    bit          busy, req_hold;
    int          rv_cnt, cyc, first_valid_cyc, stall, req_hi_cnt;
    logic [31:0] out_addr, hold_addr, want_pc;
    logic [31:0] gnt_q[$];
    logic [31:0] cons_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] memval(input logic [31:0] a);
        case (data_mode)
            0:       return a;
            1:       return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // What the core must see for pc: {illegal, instr}.
    function automatic logic [32:0] exp_entry(input logic [31:0] pc);
        logic [31:0] w;
        w = memval(pc);
`ifdef IFETCH_OPCODE_CHECK_EN
        case (w[6:0])
            7'h33, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h63, 7'h37, 7'h17, 7'h73: return {1'b0, w};
            default: return {1'b1, 32'h0000_0073};
        endcase
`else
        return {1'b0, w};
`endif
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        if ($urandom_range(0, 9) == 0) r = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
        else                           r = $urandom & 32'h0000_3FFC;
        return r;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        bus.fetch_pc_i    = RESET_PC;
        bus.instr_ready_i = 1'b0;
        bus.mem_gnt_i     = 1'b0;
        bus.mem_rvalid_i  = 1'b0;
        bus.mem_rdata_i   = '0;
        busy = 0; req_hold = 0; stall = 0; req_hi_cnt = 0;
        gnt_q.delete(); cons_q.delete();
        want_pc = RESET_PC;
        first_valid_cyc = -1;
        @(negedge clk);
        #1;
        check_eq("rst_valid",   32'(bus.instr_valid_o),   32'd0);
        check_eq("rst_req",     32'(bus.mem_req_o),       32'd0);
        check_eq("rst_addr",    bus.mem_addr_o,           32'd0);
        check_eq("rst_illegal", 32'(bus.instr_illegal_o), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        cyc = 0;
    endtask

    // One clock cycle: drive at the negedge, sample 1ns later, advance to next negedge.
    task automatic step();
        bit          busy_before, rv_now, ready_now, valid_now, req_now, gnt_now;
        logic [32:0] e;
        busy_before = busy;
        rv_now = 1'b0;
        if (busy) begin
            if (rv_cnt == 0) begin
                rv_now = 1'b1;
                busy = 0;
            end else begin
                rv_cnt--;
            end
        end
        bus.mem_rvalid_i = rv_now;
        bus.mem_rdata_i  = rv_now ? memval(out_addr) : $urandom;
        gnt_now = bus.mem_req_o && ($urandom_range(0, 99) < gnt_pct);
        bus.mem_gnt_i = gnt_now;

        if (spont_pct > 0 && stall < 20 && $urandom_range(0, 99) < spont_pct) want_pc = rand_pc();
        ready_now = ($urandom_range(0, 99) < ready_pct);
        bus.fetch_pc_i    = want_pc;
        bus.instr_ready_i = ready_now;
        #1;
        req_now   = bus.mem_req_o;
        valid_now = bus.instr_valid_o;

        if (req_now) begin
            req_hi_cnt++;
            check_eq("addr_align", 32'(bus.mem_addr_o[1:0]), 32'd0);
            check_eq("one_outstanding", 32'(busy_before), 32'd0);
        end
        if (req_hold) begin
            check_eq("req_held", 32'(req_now), 32'd1);
            check_eq("addr_stable", bus.mem_addr_o, hold_addr);
        end
        if (valid_now) begin
            e = exp_entry(want_pc);
            check_eq("instr_pc", bus.instr_pc_o, want_pc);
            check_eq("instr", bus.instr_o, e[31:0]);
            check_eq("illegal", 32'(bus.instr_illegal_o), 32'(e[32]));
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end

        req_hold  = req_now && !gnt_now;
        hold_addr = bus.mem_addr_o;
        if (req_now && gnt_now) begin
            busy = 1;
            out_addr = bus.mem_addr_o;
            rv_cnt = $urandom_range(rv_min, rv_max);
            gnt_q.push_back(bus.mem_addr_o);
        end
        if (valid_now && ready_now) begin
            cons_q.push_back(want_pc);
            want_pc = ($urandom_range(0, 99) < jump_pct) ? rand_pc() : want_pc + 32'd4;
            stall = 0;
        end else begin
            stall++;
            if (live_chk && stall > 80) begin
                check_eq("progress_stall", 32'(stall), 32'd0);
                stall = 0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_knobs(input int g, input int rdy, input int lo, input int hi, input int dm);
        gnt_pct = g; ready_pct = rdy; rv_min = lo; rv_max = hi; data_mode = dm;
        jump_pct = 0; spont_pct = 0; live_chk = 0;
    endtask

    initial begin
        // 1: zero-wait memory, data = address, latency and sequential order
        set_knobs(100, 100, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check_eq("first_valid_cycle", 32'(first_valid_cyc), 32'd3);
        check_eq("t1_consumed", 32'(cons_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_eq("t1_order", (cons_q.size() > i) ? cons_q[i] : 32'hDEAD_BEEF, 32'(4 * i));

        // 2: core stalled -> exactly DEPTH requests, then refill after one pop
        set_knobs(100, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 20; i++) step();
        check_eq("t2_grants", 32'(gnt_q.size()), 32'(DEPTH));
        check_eq("t2_req_idle", 32'(bus.mem_req_o), 32'd0);
        ready_pct = 100;
        for (int i = 0; i < 8 && gnt_q.size() < 3; i++) step();
        check_eq("t2_refill_addr", (gnt_q.size() > 2) ? gnt_q[2] : 32'hDEAD_BEEF, 32'd8);

        // 3: redirect while the read for pc 8 is outstanding
        set_knobs(100, 100, 3, 3, 1);
        do_reset();
        for (int i = 0; i < 40 && !(gnt_q.size() > 0 && gnt_q[gnt_q.size() - 1] == 32'd8); i++)
            step();
        check_eq("t3_reached_pc8", (gnt_q.size() > 0) ? gnt_q[gnt_q.size() - 1] : 32'd0, 32'd8);
        step();
        want_pc = 32'h100;
        gnt_q.delete(); cons_q.delete();
        for (int i = 0; i < 40 && cons_q.size() < 2; i++) step();
        check_eq("t3_req_addr", (gnt_q.size() > 0) ? gnt_q[0] : 32'hDEAD_BEEF, 32'h100);
        check_eq("t3_first_consumed", (cons_q.size() > 0) ? cons_q[0] : 32'hDEAD_BEEF, 32'h100);

        // 4: grant withheld, request must hold
        set_knobs(0, 100, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 7; i++) step();
        check_eq("t4_req_cycles", 32'(req_hi_cnt), 32'd6);
        gnt_pct = 100;
        for (int i = 0; i < 10; i++) step();
        check_eq("t4_progress", 32'(cons_q.size() > 0), 32'd1);

        // 5: reset asserted while waiting for read data
        set_knobs(100, 100, 4, 4, 0);
        do_reset();
        for (int i = 0; i < 10 && gnt_q.size() < 1; i++) step();
        step();
        #2 resetn = 1'b0;
        #1;
        check_eq("t5_req",     32'(bus.mem_req_o),       32'd0);
        check_eq("t5_valid",   32'(bus.instr_valid_o),   32'd0);
        check_eq("t5_addr",    bus.mem_addr_o,           32'd0);
        check_eq("t5_illegal", 32'(bus.instr_illegal_o), 32'd0);
        set_knobs(100, 100, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check_eq("t5_first_valid", 32'(first_valid_cyc), 32'd3);
        check_eq("t5_refetch", (gnt_q.size() > 0) ? gnt_q[0] : 32'hDEAD_BEEF, RESET_PC);

        // address wrap and misaligned redirect
        set_knobs(100, 100, 0, 1, 1);
        do_reset();
        want_pc = 32'hFFFF_FFF8;
        for (int i = 0; i < 40 && cons_q.size() < 3; i++) step();
        check_eq("wrap_0", (cons_q.size() > 0) ? cons_q[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        check_eq("wrap_2", (cons_q.size() > 2) ? cons_q[2] : 32'hDEAD_BEEF, 32'h0000_0000);
        want_pc = 32'h203;
        step();
        want_pc = 32'h200;
        cons_q.delete();
        for (int i = 0; i < 30 && cons_q.size() < 1; i++) step();
        check_eq("misaligned_recover", (cons_q.size() > 0) ? cons_q[0] : 32'hDEAD_BEEF, 32'h200);

        // 6: all-ones memory word
        set_knobs(100, 0, 0, 0, 2);
        do_reset();
        for (int i = 0; i < 6; i++) step();
        check_eq("t6_valid", 32'(bus.instr_valid_o), 32'd1);
`ifdef IFETCH_OPCODE_CHECK_EN
        check_eq("t6_instr",   bus.instr_o,              32'h0000_0073);
        check_eq("t6_illegal", 32'(bus.instr_illegal_o), 32'd1);
`else
        check_eq("t6_instr",   bus.instr_o,              32'hFFFF_FFFF);
        check_eq("t6_illegal", 32'(bus.instr_illegal_o), 32'd0);
`endif

        // randomized traffic against the reference model
        set_knobs(60, 70, 0, 3, 1);
        jump_pct = 10; spont_pct = 1; live_chk = 1;
        do_reset();
        for (int i = 0; i < 3000; i++) step();
        check_eq("rand_throughput", 32'(cons_q.size() > 200), 32'd1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
